// File: rtl/cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_bus_arbiter
//
// Shares one SRAM-like bus (split address / data handshakes, one transaction
// outstanding) between the instruction-fetch port and the MEM-stage data
// port. Data accesses win arbitration. Returned words are held in registers
// until the pipeline advances. kseg0/kseg1 virtual addresses are mapped to
// physical addresses. Fetches hit by an exception flush still complete on the
// bus, but their data is discarded.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   inst_req, if_pc     fetch request and virtual address
//   if_instr            registered fetched word
//   stallreq_from_if    fetch still pending (combinational)
//   mem_en, mem_we      data access request, 1 = store
//   mem_size, sel       access size (0 byte, 1 half, 2 word), store strobes
//   data_addr           data virtual address
//   mem_wdata_last      store data
//   mem_rdata           registered load word
//   stallreq_from_mem   data access still pending (combinational)
//   pipe_stall          some pipeline stage is held this cycle
//   flush               exception flush
//   bus_req/wr/size/addr/wstrb/wdata   registered request channel
//   bus_addr_ok         request accepted
//   bus_data_ok         response valid
//   bus_rdata           response data
// -----------------------------------------------------------------------------
module cpu_bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        stallreq_from_if,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic [3:0]  sel,
  input  logic [31:0] data_addr,
  input  logic [31:0] mem_wdata_last,
  output logic [31:0] mem_rdata,
  output logic        stallreq_from_mem,
  input  logic        pipe_stall,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_ADDR = 3'd1,
    I_DATA = 3'd2,
    D_ADDR = 3'd3,
    D_DATA = 3'd4
  } state_t;

  state_t state_r;
  logic   inst_done_r;
  logic   data_done_r;
  logic   drop_r;

  logic   inst_fin_s;
  logic   data_fin_s;
  logic   drop_eff_s;

  // kseg0 (0x8000_0000) and kseg1 (0xA000_0000) both alias physical 0.
  function automatic logic [31:0] map_addr(input logic [31:0] va);
    if ((va[31:29] == 3'b100) || (va[31:29] == 3'b101)) begin
      map_addr = {3'b000, va[28:0]};
    end else begin
      map_addr = va;
    end
  endfunction

  // Completion strobes; a flush arriving in the completing cycle also discards.
  always_comb begin
    inst_fin_s = (state_r == I_DATA) && bus_data_ok;
    data_fin_s = (state_r == D_DATA) && bus_data_ok;
    drop_eff_s = drop_r | flush;
  end

  // Stall requests: pending until the matching done flag is set.
  assign stallreq_from_if  = inst_req & ~inst_done_r;
  assign stallreq_from_mem = mem_en & ~data_done_r;

  // Arbitration FSM, done/drop flags, registered bus request and read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      inst_done_r <= 1'b0;
      data_done_r <= 1'b0;
      drop_r      <= 1'b0;
      if_instr    <= 32'h0000_0000;
      mem_rdata   <= 32'h0000_0000;
      bus_req     <= 1'b0;
      bus_wr      <= 1'b0;
      bus_size    <= 2'd0;
      bus_addr    <= 32'h0000_0000;
      bus_wstrb   <= 4'b0000;
      bus_wdata   <= 32'h0000_0000;
    end else begin
      // Done flags survive a held pipeline so a finished access is not
      // re-issued; setting wins only in the completing cycle.
      if (inst_fin_s && !drop_eff_s) begin
        inst_done_r <= 1'b1;
      end else if (!pipe_stall || flush) begin
        inst_done_r <= 1'b0;
      end else begin
        inst_done_r <= inst_done_r;
      end

      if (data_fin_s) begin
        data_done_r <= 1'b1;
      end else if (!pipe_stall || flush) begin
        data_done_r <= 1'b0;
      end else begin
        data_done_r <= data_done_r;
      end

      case (state_r)
        IDLE: begin
          if (mem_en && !data_done_r && !flush) begin
            state_r   <= D_ADDR;
            bus_req   <= 1'b1;
            bus_wr    <= mem_we;
            bus_size  <= mem_size;
            bus_addr  <= map_addr(data_addr);
            bus_wstrb <= mem_we ? sel : 4'b0000;
            bus_wdata <= mem_we ? mem_wdata_last : 32'h0000_0000;
          end else if (inst_req && !inst_done_r && !flush) begin
            state_r   <= I_ADDR;
            bus_req   <= 1'b1;
            bus_wr    <= 1'b0;
            bus_size  <= 2'd2;
            bus_addr  <= map_addr(if_pc);
            bus_wstrb <= 4'b0000;
            bus_wdata <= 32'h0000_0000;
          end else begin
            state_r <= IDLE;
          end
        end
        I_ADDR: begin
          // The request stays up even when flushed; only the result is dropped.
          if (flush) begin
            drop_r <= 1'b1;
          end
          if (bus_addr_ok) begin
            state_r <= I_DATA;
            bus_req <= 1'b0;
          end
        end
        I_DATA: begin
          if (bus_data_ok) begin
            state_r <= IDLE;
            drop_r  <= 1'b0;
            if (!drop_eff_s) begin
              if_instr <= bus_rdata;
            end
          end else if (flush) begin
            drop_r <= 1'b1;
          end
        end
        D_ADDR: begin
          if (bus_addr_ok) begin
            state_r <= D_DATA;
            bus_req <= 1'b0;
          end
        end
        D_DATA: begin
          if (bus_data_ok) begin
            state_r <= IDLE;
            if (!bus_wr) begin
              mem_rdata <= bus_rdata;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cpu_bus_arbiter
//
// Directed bench for cpu_bus_arbiter. Inputs change 1 time unit after each
// rising edge; outputs are checked at the same point, so every check sees the
// registers updated by the preceding edge.
// -----------------------------------------------------------------------------
module tb_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        stallreq_from_if;
  logic        mem_en;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [3:0]  sel;
  logic [31:0] data_addr;
  logic [31:0] mem_wdata_last;
  logic [31:0] mem_rdata;
  logic        stallreq_from_mem;
  logic        pipe_stall;
  logic        flush;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  cpu_bus_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .inst_req          (inst_req),
    .if_pc             (if_pc),
    .if_instr          (if_instr),
    .stallreq_from_if  (stallreq_from_if),
    .mem_en            (mem_en),
    .mem_we            (mem_we),
    .mem_size          (mem_size),
    .sel               (sel),
    .data_addr         (data_addr),
    .mem_wdata_last    (mem_wdata_last),
    .mem_rdata         (mem_rdata),
    .stallreq_from_mem (stallreq_from_mem),
    .pipe_stall        (pipe_stall),
    .flush             (flush),
    .bus_req           (bus_req),
    .bus_wr            (bus_wr),
    .bus_size          (bus_size),
    .bus_addr          (bus_addr),
    .bus_wstrb         (bus_wstrb),
    .bus_wdata         (bus_wdata),
    .bus_addr_ok       (bus_addr_ok),
    .bus_data_ok       (bus_data_ok),
    .bus_rdata         (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; inst_req = 1'b0; if_pc = 32'h0; mem_en = 1'b0; mem_we = 1'b0;
    mem_size = 2'd0; sel = 4'b0000; data_addr = 32'h0; mem_wdata_last = 32'h0;
    pipe_stall = 1'b0; flush = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    bus_rdata = 32'h0;

    // Reset state
    step(); step();
    chk("rst_bus_req",  32'(bus_req),   32'h0);
    chk("rst_bus_addr", bus_addr,       32'h0);
    chk("rst_wstrb",    32'(bus_wstrb), 32'h0);
    chk("rst_bus_wr",   32'(bus_wr),    32'h0);
    chk("rst_if_instr", if_instr,       32'h0);
    chk("rst_mem_rdata", mem_rdata,     32'h0);
    inst_req = 1'b1; if_pc = 32'hBFC0_0000; pipe_stall = 1'b1;
    #1;
    chk("rst_stall_if", 32'(stallreq_from_if), 32'h1);

    // Best-case fetch from kseg1
    rst = 1'b1;
    step();                               // IDLE -> I_ADDR
    chk("f1_req",  32'(bus_req),  32'h1);
    chk("f1_addr", bus_addr,      32'h1FC0_0000);
    chk("f1_size", 32'(bus_size), 32'h2);
    chk("f1_wr",   32'(bus_wr),   32'h0);
    chk("f1_stall", 32'(stallreq_from_if), 32'h1);
    bus_addr_ok = 1'b1;
    step();                               // I_DATA
    chk("f1_req_low", 32'(bus_req), 32'h0);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h3C08_0001;
    step();                               // IDLE, done
    bus_data_ok = 1'b0;
    chk("f1_instr", if_instr, 32'h3C08_0001);
    chk("f1_stall_rel", 32'(stallreq_from_if), 32'h0);
    inst_req = 1'b0; pipe_stall = 1'b0;
    step();

    // Simultaneous fetch and load: data first
    inst_req = 1'b1; if_pc = 32'h8000_0100; pipe_stall = 1'b1;
    mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'd2; data_addr = 32'h8000_1000;
    step();                               // D_ADDR
    chk("d1_req",   32'(bus_req),   32'h1);
    chk("d1_addr",  bus_addr,       32'h0000_1000);
    chk("d1_wstrb", 32'(bus_wstrb), 32'h0);
    chk("d1_wr",    32'(bus_wr),    32'h0);
    bus_addr_ok = 1'b1;
    step();                               // D_DATA
    chk("d1_req_low", 32'(bus_req), 32'h0);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
    step();                               // IDLE, data done
    bus_data_ok = 1'b0;
    chk("d1_rdata", mem_rdata, 32'h1234_5678);
    chk("d1_stall_mem", 32'(stallreq_from_mem), 32'h0);
    chk("d1_idle_gap", 32'(bus_req), 32'h0);
    chk("d1_fetch_wait", 32'(stallreq_from_if), 32'h1);
    step();                               // I_ADDR
    chk("d1_fetch_req",  32'(bus_req), 32'h1);
    chk("d1_fetch_addr", bus_addr,     32'h0000_0100);
    chk("d1_mem_hold",   32'(stallreq_from_mem), 32'h0);
    bus_addr_ok = 1'b1;
    step();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h2402_0005;
    step();
    bus_data_ok = 1'b0;
    chk("d1_fetch_instr", if_instr, 32'h2402_0005);
    chk("d1_fetch_stall", 32'(stallreq_from_if), 32'h0);
    inst_req = 1'b0; mem_en = 1'b0; pipe_stall = 1'b0;
    step();

    // Byte store with bus_addr_ok held off for 3 cycles
    mem_en = 1'b1; mem_we = 1'b1; mem_size = 2'd0; sel = 4'b0100;
    mem_wdata_last = 32'h00AB_0000; data_addr = 32'hA000_2002; pipe_stall = 1'b1;
    step();                               // D_ADDR
    for (int i = 0; i < 4; i++) begin
      chk("st_req",   32'(bus_req),   32'h1);
      chk("st_wr",    32'(bus_wr),    32'h1);
      chk("st_wstrb", 32'(bus_wstrb), 32'h4);
      chk("st_wdata", bus_wdata,      32'h00AB_0000);
      chk("st_addr",  bus_addr,       32'h0000_2002);
      chk("st_size",  32'(bus_size),  32'h0);
      if (i == 3) bus_addr_ok = 1'b1;
      step();
    end
    chk("st_req_low", 32'(bus_req), 32'h0);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    step();
    bus_data_ok = 1'b0;
    chk("st_rdata_keep", mem_rdata, 32'h1234_5678);
    chk("st_stall_rel", 32'(stallreq_from_mem), 32'h0);
    mem_en = 1'b0; mem_we = 1'b0; pipe_stall = 1'b0;
    step();

    // Flush during I_DATA: result discarded, fetch re-issued
    inst_req = 1'b1; if_pc = 32'hBFC0_0004; pipe_stall = 1'b1;
    step();                               // I_ADDR
    chk("fl_addr", bus_addr, 32'h1FC0_0004);
    bus_addr_ok = 1'b1;
    step();                               // I_DATA
    bus_addr_ok = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    step();                               // IDLE, dropped
    bus_data_ok = 1'b0;
    chk("fl_instr_keep", if_instr, 32'h2402_0005);
    chk("fl_not_done", 32'(stallreq_from_if), 32'h1);
    chk("fl_idle", 32'(bus_req), 32'h0);
    step();                               // re-issue
    chk("fl_reissue_req",  32'(bus_req), 32'h1);
    chk("fl_reissue_addr", bus_addr,     32'h1FC0_0004);

    // Completion under a 5-cycle pipeline stall
    bus_addr_ok = 1'b1;
    step();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h8C43_0010;
    step();                               // done
    bus_data_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("ps_stall_if", 32'(stallreq_from_if), 32'h0);
      chk("ps_no_req",   32'(bus_req),          32'h0);
      chk("ps_instr",    if_instr,              32'h8C43_0010);
      if (i == 4) pipe_stall = 1'b0;
      step();
    end
    chk("ps_cleared", 32'(stallreq_from_if), 32'h1);
    chk("ps_cleared_req", 32'(bus_req), 32'h0);
    inst_req = 1'b0;
    step();

    // Reset in D_ADDR (unmapped address passes through)
    mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'd2; data_addr = 32'h0000_4000;
    pipe_stall = 1'b1;
    step();                               // D_ADDR
    chk("rs_req",  32'(bus_req), 32'h1);
    chk("rs_addr", bus_addr,     32'h0000_4000);
    rst = 1'b0;
    step();
    chk("rs_req_low", 32'(bus_req), 32'h0);
    chk("rs_rdata",   mem_rdata,    32'h0);
    chk("rs_instr",   if_instr,     32'h0);
    chk("rs_addr0",   bus_addr,     32'h0);
    chk("rs_stall_mem", 32'(stallreq_from_mem), 32'h1);

    // Flush at the IDLE decision blocks the issue
    rst = 1'b1; flush = 1'b1;
    step();
    chk("fi_no_issue", 32'(bus_req), 32'h0);
    flush = 1'b0;
    step();
    chk("fi_issue", 32'(bus_req), 32'h1);
    bus_addr_ok = 1'b1;
    step();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000_CAFE;
    step();
    bus_data_ok = 1'b0;
    chk("fi_rdata", mem_rdata, 32'h0000_CAFE);
    mem_en = 1'b0; pipe_stall = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cpu_bus_arbiter.md
# cpu_bus_arbiter

Arbitrates the datapath's instruction-fetch port and MEM-stage data port onto one shared SRAM-like bus with split address/data handshakes, one transaction outstanding at a time. It sits between the datapath and the bus bridge and generates `stallreq_from_if` / `stallreq_from_mem`. It latches returned data until the pipeline advances, maps kseg0/kseg1 to physical addresses, and discards fetches cancelled by an exception flush.

## Interface
Parameters:
- None.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-low reset
- `inst_req`  in  1  fetch wanted at `if_pc`
- `if_pc`  in  32  fetch virtual address
- `if_instr`  out  32  registered fetched word
- `stallreq_from_if`  out  1  fetch not yet complete
- `mem_en`  in  1  data access wanted
- `mem_we`  in  1  1 = store
- `mem_size`  in  2  0 = byte, 1 = half, 2 = word
- `sel`  in  4  store byte strobes
- `data_addr`  in  32  data virtual address
- `mem_wdata_last`  in  32  store data
- `mem_rdata`  out  32  registered load word
- `stallreq_from_mem`  out  1  data access not yet complete
- `pipe_stall`  in  1  any pipeline stage held this cycle
- `flush`  in  1  exception flush
- `bus_req`  out  1  request valid
- `bus_wr`  out  1  write
- `bus_size`  out  2  access size
- `bus_addr`  out  32  physical address
- `bus_wstrb`  out  4  byte strobes; 0 on reads
- `bus_wdata`  out  32  write data
- `bus_addr_ok`  in  1  request accepted
- `bus_data_ok`  in  1  response valid
- `bus_rdata`  in  32  read data

## Operation
- FSM states:
  - `IDLE`, `I_ADDR`, `I_DATA`, `D_ADDR`, `D_DATA`.
  - All bus outputs are registered and loaded on the `IDLE` exit edge.
- `IDLE` arbitration (data has priority):
  - If `mem_en & ~data_done & ~flush`, go to `D_ADDR`.
  - Else if `inst_req & ~inst_done & ~flush`, go to `I_ADDR`.
  - Else stay in `IDLE`.
- `X_ADDR` (either side):
  - `bus_req` = 1, with addr/size/wr/wstrb/wdata held stable.
  - On `bus_addr_ok`, go to `X_DATA` and `bus_req` = 0.
  - A request is never withdrawn, even under `flush`.
- `X_DATA`:
  - On `bus_data_ok`, go to `IDLE`.
  - Loads/fetches latch `bus_rdata` into `mem_rdata` / `if_instr`.
  - Set `data_done` / `inst_done`, unless `drop` is set; in that case clear `drop` and latch nothing.
  - `bus_data_ok` is only honoured in `*_DATA` states.
- Fetch flush:
  - `flush` in `I_ADDR` or `I_DATA` sets `drop`; the fetch completes on the bus and is discarded.
  - Data transactions already issued always complete and are never dropped; the MEM-stage flush arrives only after issue.
- Address map:
  - `addr[31:29]` of 3'b100 or 3'b101 gives `{3'b000, addr[28:0]}`; otherwise the address passes through.
- Stall outputs (combinational):
  - `stallreq_from_if` = `inst_req & ~inst_done`.
  - `stallreq_from_mem` = `mem_en & ~data_done`.
- Done flags:
  - Both are cleared on any edge with `pipe_stall`=0 (the pipeline consumed the data) or `flush`=1.
  - Set has priority over clear only in the completing cycle.
  - A done flag stays at 1 while `pipe_stall`=1, so a completed fetch is not re-issued while MEM stalls.

## Timing
- Reset values: state `IDLE`, `inst_done`=`data_done`=`drop`=0, `if_instr`=`mem_rdata`=0, all `bus_*` outputs 0.
- While `inst_req`=1 out of reset, `stallreq_from_if`=1.
- Reset mid-transaction: FSM returns to `IDLE`, `bus_req` drops, in-flight data is lost. The bus side is reset by the same `rst`.
- Best-case latency:
  - Cycle 0: request seen in `IDLE`.
  - Cycle 1: `bus_req`=1, `bus_addr_ok`=1.
  - Cycle 2: `bus_data_ok`=1.
  - Cycle 3: done=1, stall low, data valid.
  - Total: 3 cycles from request to stall release.
- Simultaneous fetch and data requests: data first. The fetch is issued from `IDLE` the cycle after the data transaction completes, i.e. 1 idle cycle between transactions.
- `bus_addr_ok` held low for N cycles: the request stays asserted and unchanged for N+1 cycles.
- `flush` in the same cycle as the `IDLE` decision: no issue.

## Test plan
- Fetch 0xBFC00000, `bus_addr_ok` at cycle 1, `bus_data_ok` at cycle 2 with 0x3C080001 → `bus_addr`=0x1FC00000; `if_instr`=0x3C080001 and `stallreq_from_if`=0 at cycle 3.
- `inst_req` and `mem_en` (load, 0x80001000) raised together → the data transaction goes first with `bus_addr`=0x00001000, `bus_wstrb`=0; the fetch is issued only after `bus_data_ok`.
- Store byte, `sel`=4'b0100, `mem_wdata_last`=0x00AB0000, `bus_addr_ok` delayed 3 cycles → `bus_req` high 4 cycles, `bus_wr`=1, `bus_wstrb`=4'b0100, outputs stable throughout.
- `flush` during `I_DATA`, then `bus_data_ok` with 0xDEADBEEF → `if_instr` unchanged, `inst_done`=0, a new fetch issued from `IDLE`.
- Fetch completes while `pipe_stall`=1 for 5 cycles → `inst_done` stays 1, no second bus request, `if_instr` stable; clears on the first edge with `pipe_stall`=0.
- `rst`=0 asserted in `D_ADDR` → next cycle state `IDLE`, `bus_req`=0, `mem_rdata`=0.
